// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by the fetch stage.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_IMEM_WORDS = 65;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Redirect targets are forced onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with clear (highest priority), load and hold.
module ifid_pipe_reg
  import cpu_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clear_i,
  input  logic  load_i,
  input  ifid_t data_i,
  output ifid_t q_o
);

  localparam ifid_t IFID_EMPTY = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

  ifid_t ifid_q;
  ifid_t ifid_d;

  // Next IF/ID contents: clear beats load, otherwise hold
  always_comb begin
    ifid_d = ifid_q;
    if (clear_i) begin
      ifid_d = IFID_EMPTY;
    end else if (load_i) begin
      ifid_d = data_i;
    end
  end

  // IF/ID state register, cleared asynchronously to a NOP bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_q <= IFID_EMPTY;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage front end: PC register, next-PC selection, IF/ID capture and
// sticky out-of-range fault. Defining IF_PERF_CNT_EN adds fetch/stall counters.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0]  RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned  IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        ifid_valid_o,
  output logic        fetch_fault_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect;
  logic            in_range;
  logic            fault_q;
  logic            fault_d;
  logic            ifid_clear;
  logic            ifid_load;
  ifid_t           ifid_data;
  ifid_t           ifid_q;

  assign redirect = jump_i | branch_taken_i;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign in_range = XLEN'(pc_q[XLEN-1:2]) < IMEM_WORDS;

  // Next PC: jump, then branch, then stall hold, then sequential
  always_comb begin
    pc_d = pc_plus4;
    if (jump_i) begin
      pc_d = word_align(jump_target_i);
    end else if (branch_taken_i) begin
      pc_d = word_align(branch_target_i);
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  // IF/ID controls; out-of-range fetches and redirects/flushes become bubbles
  always_comb begin
    ifid_clear = redirect | flush_i | (~stall_i & ~in_range);
    ifid_load  = ~stall_i & in_range;
    ifid_data  = '{instr: imem_instr_i, pc_plus4: pc_plus4, valid: 1'b1};
    fault_d    = fault_q | (~stall_i & ~in_range);
  end

  // PC and sticky fault registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  ifid_pipe_reg u_ifid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (ifid_clear),
    .load_i  (ifid_load),
    .data_i  (ifid_data),
    .q_o     (ifid_q)
  );

  assign imem_addr_o     = pc_q;
  assign ifid_instr_o    = ifid_q.instr;
  assign ifid_pc_plus4_o = ifid_q.pc_plus4;
  assign ifid_valid_o    = ifid_q.valid;
  assign fetch_fault_o   = fault_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count valid IF/ID loads and stall-held edges (redirects are not stalls)
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (ifid_load && !ifid_clear) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (stall_i && !redirect) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver pushes model expectations,
// monitor pops and compares after each rising edge.
module tb_instr_fetch_unit;

  localparam int unsigned WORDS = 65;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = '0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_plus4_o;
  logic        ifid_valid_o;
  logic        fetch_fault_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_instr_i    (imem_instr_i),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc_plus4_o (ifid_pc_plus4_o),
    .ifid_valid_o    (ifid_valid_o),
    .fetch_fault_o   (fetch_fault_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o     (fetch_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory: combinational word read, recognisable garbage past the end
  logic [31:0] mem [WORDS];
  always_comb begin
    if (imem_addr_o[31:2] < 30'(WORDS)) imem_instr_i = mem[imem_addr_o[31:2]];
    else                                imem_instr_i = 32'hBAD0_0000 ^ imem_addr_o;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        chk_pp4;
    logic        fault;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_fcnt, m_scnt;
  logic        m_valid, m_fault, m_pp4_known;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    m_pp4_known = 1'b1; m_fault = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
  endtask

  // One clock of stimulus; model computes the state after the coming edge
  task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    exp_t e;
    logic redir, inr;
    @(negedge clk_i);
    stall_i = st; flush_i = fl; branch_taken_i = br; branch_target_i = bt;
    jump_i = jp; jump_target_i = jt;
    redir = jp | br;
    inr   = (m_pc / 4) < WORDS;
    if (!st && !inr) m_fault = 1'b1;
    if (st && !redir) m_scnt = m_scnt + 1;
    if (redir || fl) begin
      m_instr = 0; m_pp4 = 0; m_valid = 0; m_pp4_known = 1;
    end else if (st) begin
      // IF/ID holds
    end else if (inr) begin
      m_instr = mem[m_pc / 4]; m_pp4 = m_pc + 4; m_valid = 1; m_pp4_known = 1;
      m_fcnt = m_fcnt + 1;
    end else begin
      m_instr = 0; m_valid = 0; m_pp4_known = 0;
    end
    if (jp)      m_pc = {jt[31:2], 2'b00};
    else if (br) m_pc = {bt[31:2], 2'b00};
    else if (!st) m_pc = m_pc + 4;
    e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid;
    e.chk_pp4 = m_pp4_known; e.fault = m_fault; e.fcnt = m_fcnt; e.scnt = m_scnt;
    sb_q.push_back(e);
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  // Immediate check of the reset state, used while rst_i is asserted
  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, imem_addr_o, 32'h0);
    chk({tag, "_instr"}, ifid_instr_o, 32'h0);
    chk({tag, "_pp4"}, ifid_pc_plus4_o, 32'h0);
    chk({tag, "_valid"}, 32'(ifid_valid_o), 32'h0);
    chk({tag, "_fault"}, 32'(fetch_fault_o), 32'h0);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_fcnt"}, fetch_cnt_o, 32'h0);
    chk({tag, "_scnt"}, stall_cnt_o, 32'h0);
`endif
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge
  task automatic async_reset(input string tag);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0;
    #1;
    chk_reset_state(tag);
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
  endtask

  // Monitor: compare DUT against the oldest expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc", imem_addr_o, e.pc);
        chk("instr", ifid_instr_o, e.instr);
        chk("valid", 32'(ifid_valid_o), 32'(e.valid));
        if (e.chk_pp4) chk("pc_plus4", ifid_pc_plus4_o, e.pp4);
        chk("fault", 32'(fetch_fault_o), 32'(e.fault));
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt_o, e.fcnt);
        chk("stall_cnt", stall_cnt_o, e.scnt);
`endif
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
    model_reset();
    #12;
    chk_reset_state("reset");
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;

    // Sequential fetch A, B then two-cycle stall at pc=8, resume with C
    plain(2);
    step(1, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 0, 32'h0);
    plain(2);
    // Branch to unaligned 0x23 while stalled, then fetch word 8
    step(1, 0, 1, 32'h23, 0, 32'h0);
    plain(2);
    // Jump beats branch
    step(0, 0, 1, 32'h80, 1, 32'h40);
    plain(1);
    // Flush with stall: PC holds, IF/ID cleared
    step(1, 1, 0, 32'h0, 0, 32'h0);
    plain(2);

    // Mid-stream reset at pc=0x10
    async_reset("rst_pre");
    plain(4);
    async_reset("rst_mid");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic st, fl, br, jp;
      logic [31:0] bt, jt;
      st = ($urandom % 10) < 3;
      fl = ($urandom % 10) < 1;
      br = ($urandom % 10) < 1;
      jp = ($urandom % 20) < 1;
      bt = $urandom_range(0, 300);
      jt = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 280));
      step(st, fl, br, bt, jp, jt);
    end

    // Run off the end of memory: fault sets and stays, IF/ID stays invalid
    async_reset("rst_run");
    plain(70);
    step(1, 0, 0, 32'h0, 0, 32'h0);
    plain(2);

    // PC wrap from 0xFFFF_FFFC to 0
    step(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF);
    plain(2);

    async_reset("rst_end");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk_i);
    #2;
    if (sb_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the CPU fetch stage: holds the program counter and drives the instruction-memory address.
- Computes the next PC from sequential, branch and jump sources.
- Captures the returned instruction into the IF/ID pipeline register with stall and flush control.
- Sits directly upstream of the instruction memory (combinational word read at addr/4) and feeds the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 65, number of 32-bit words in instruction memory; fetches at or beyond this index are faults.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- stall_i  input  1  hazard-unit hold: freeze PC and IF/ID.
- flush_i  input  1  squash IF/ID contents (insert NOP).
- branch_taken_i  input  1  taken branch resolved downstream.
- branch_target_i  input  32  branch destination byte address.
- jump_i  input  1  jump resolved in decode.
- jump_target_i  input  32  jump destination byte address.
- imem_addr_o  output  32  byte address to instruction memory (= PC register).
- imem_instr_i  input  32  instruction word returned combinationally.
- ifid_instr_o  output  32  registered instruction to decode.
- ifid_pc_plus4_o  output  32  registered PC+4 of that instruction.
- ifid_valid_o  output  1  IF/ID holds a real instruction.
- fetch_fault_o  output  1  sticky: PC left instruction memory range.

Behaviour:
- Reset (asynchronous, effective immediately, also mid-operation):
  - pc=RESET_PC.
  - ifid_instr_o=32'h0 (NOP), ifid_pc_plus4_o=0, ifid_valid_o=0, fetch_fault_o=0.
- imem_addr_o = pc (register output, no combinational path from inputs).
- Next-PC priority, evaluated each rising edge:
  - jump_i -> jump_target_i.
  - else branch_taken_i -> branch_target_i.
  - else stall_i -> hold pc.
  - else pc+4.
- Redirect (jump_i or branch_taken_i) overrides stall_i.
- Targets have bits [1:0] forced to 0 before loading.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- IF/ID update, per edge, in priority order:
  - redirect or flush_i: instr<=0, valid<=0, pc_plus4<=0.
  - else stall_i: all IF/ID fields hold.
  - else in range: instr<=imem_instr_i, pc_plus4<=pc+4, valid<=1.
  - else out of range: instr<=0, valid<=0.
- In range means pc[31:2] < IMEM_WORDS.
- Fault: fetch_fault_o goes to 1 on the first non-stalled edge where pc[31:2] >= IMEM_WORDS; it stays 1 until reset.
- Latency: the instruction at PC appears on ifid_instr_o one edge after pc is presented. The first valid word after reset release appears after the first rising edge.
- Simultaneous events:
  - flush_i with stall_i: flush wins for IF/ID, and PC holds (unless a redirect is present).
  - branch_taken_i with jump_i: jump wins.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds outputs:
  - fetch_cnt_o[31:0]: counts edges where IF/ID loads valid=1.
  - stall_cnt_o[31:0]: counts edges where stall_i holds without a redirect.
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=32, NOP_INSTR=32'h0, DEFAULT_RESET_PC.
  - typedef ifid_t: struct {instr, pc_plus4, valid}.
- One natural sub-module: ifid_pipe_reg, the IF/ID register with load/hold/clear controls.
- PC and next-PC logic stay in the top module.

Test Plan:
- Reset release, memory words 0..3 = A,B,C,D, no stall:
  - imem_addr_o steps 0,4,8,12.
  - ifid outputs (A,4,1), (B,8,1), (C,12,1) on successive edges.
- stall_i high for 2 cycles at pc=8:
  - pc holds 8.
  - ifid holds (B,8,1) for both cycles.
  - fetch resumes with C.
- branch_taken_i=1, target=32'h23 while stall_i=1:
  - pc=32'h20 next edge.
  - ifid valid=0, instr=0.
  - following edge fetches word 8.
- jump_i and branch_taken_i together, targets 0x40 and 0x80:
  - pc=0x40.
- pc reaches 65*4=260 with no stall:
  - fetch_fault_o=1.
  - ifid valid=0 and stays invalid.
  - fetch_fault_o stays 1 until rst_i pulse.
- rst_i asserted mid-stream at pc=0x10:
  - pc=0 and ifid cleared immediately, without a clock edge.
  - with IF_PERF_CNT_EN defined, counters read 0.
